// File: rtl/fpu_pkg.sv
// Shared FPU definitions: opcode bit positions, default latencies and the
// writeback reservation entry used by the issue scheduler.
package fpu_pkg;

    localparam int OP_MADD   = 16;
    localparam int OP_MSUB   = 15;
    localparam int OP_NMADD  = 14;
    localparam int OP_NMSUB  = 13;
    localparam int OP_ADD    = 12;
    localparam int OP_SUB    = 11;
    localparam int OP_MUL    = 10;
    localparam int OP_SGNJ   = 9;
    localparam int OP_CMP    = 8;
    localparam int OP_MINMAX = 7;
    localparam int OP_CLASS  = 6;
    localparam int OP_I2F    = 3;
    localparam int OP_F2I    = 2;

    localparam int DEF_NUM_BANK      = 8;
    localparam int DEF_ADDR_WIDTH    = 5;
    localparam int DEF_PIPE_LATENCY  = 4;
    localparam int DEF_SHORT_LATENCY = 1;

    // An all-zero write_en marks an empty reservation slot.
    typedef struct packed {
        logic [DEF_NUM_BANK-1:0]   write_en;
        logic [DEF_ADDR_WIDTH-1:0] write_addr;
    } resv_entry_t;

endpackage

// File: rtl/fpu_issue_scheduler_if.sv
// Decode-to-FPU issue bundle: decoded op and handshake in, issued op,
// register-file write strobe and busy flag out.
interface fpu_issue_scheduler_if #(
    parameter int TotalNumBank = 8,
    parameter int AddrWidth    = 5
);
    localparam int BankW = $clog2(TotalNumBank);

    logic                    dec_valid;
    logic                    dec_ready;
    logic [16:0]             dec_fp_opcode;
    logic                    dec_fp_en;
    logic [2:0]              dec_fp_rm;
    logic [TotalNumBank-1:0] dec_writeEn;
    logic [AddrWidth-1:0]    dec_writeAddr;
    logic                    dec_pipe;
    logic                    dec_ALUSrc;
    logic [BankW-1:0]        dec_rs1_bank, dec_rs2_bank, dec_rs3_bank;
    logic [AddrWidth-1:0]    dec_rs1_addr, dec_rs2_addr, dec_rs3_addr;
    logic [2:0]              dec_rs_used;

    logic                    iss_valid;
    logic [16:0]             iss_fp_opcode;
    logic [2:0]              iss_fp_rm;
    logic                    iss_ALUSrc;
    logic                    wb_valid;
    logic [TotalNumBank-1:0] wb_writeEn;
    logic [AddrWidth-1:0]    wb_writeAddr;
    logic                    busy;

    modport master (
        output dec_valid, dec_fp_opcode, dec_fp_en, dec_fp_rm, dec_writeEn, dec_writeAddr,
               dec_pipe, dec_ALUSrc, dec_rs1_bank, dec_rs2_bank, dec_rs3_bank,
               dec_rs1_addr, dec_rs2_addr, dec_rs3_addr, dec_rs_used,
        input  dec_ready, iss_valid, iss_fp_opcode, iss_fp_rm, iss_ALUSrc,
               wb_valid, wb_writeEn, wb_writeAddr, busy
    );

    modport slave (
        input  dec_valid, dec_fp_opcode, dec_fp_en, dec_fp_rm, dec_writeEn, dec_writeAddr,
               dec_pipe, dec_ALUSrc, dec_rs1_bank, dec_rs2_bank, dec_rs3_bank,
               dec_rs1_addr, dec_rs2_addr, dec_rs3_addr, dec_rs_used,
        output dec_ready, iss_valid, iss_fp_opcode, iss_fp_rm, iss_ALUSrc,
               wb_valid, wb_writeEn, wb_writeAddr, busy
    );

endinterface

// File: rtl/fpu_scoreboard.sv
// Per-bank register busy array: three source read ports, one row read for
// destination checks, one set port and one clear port (set wins).
module fpu_scoreboard #(
    parameter int NumBank   = 8,
    parameter int AddrWidth = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [2:0][$clog2(NumBank)-1:0]     rd_bank,
    input  logic [2:0][AddrWidth-1:0]           rd_addr,
    output logic [2:0]                          rd_busy,
    input  logic [AddrWidth-1:0]                row_addr,
    output logic [NumBank-1:0]                  row_busy,
    input  logic [NumBank-1:0]                  set_mask,
    input  logic [AddrWidth-1:0]                set_addr,
    input  logic [NumBank-1:0]                  clr_mask,
    input  logic [AddrWidth-1:0]                clr_addr
);
    localparam int Depth = 1 << AddrWidth;

    logic [NumBank-1:0] busy_q [Depth];

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < 3; k++) begin
            rd_busy[k] = busy_q[rd_addr[k]][rd_bank[k]];
        end
    end

    assign row_busy = busy_q[row_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < Depth; a++) begin
                busy_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < Depth; a++) begin
                busy_q[a] <= (busy_q[a] & ~((clr_addr == AddrWidth'(a)) ? clr_mask : '0))
                           | ((set_addr == AddrWidth'(a)) ? set_mask : '0);
            end
        end
    end

endmodule

// File: rtl/fpu_issue_scheduler.sv
// FP issue scheduler: RAW/WAW scoreboard stalls, writeback-port reservation, issue
// and result write strobe. Define FPU_SCHED_EARLY_RELEASE_EN to free registers in their wb cycle.
module fpu_issue_scheduler
    import fpu_pkg::*;
#(
    parameter int TotalNumBank = DEF_NUM_BANK,
    parameter int AddrWidth    = DEF_ADDR_WIDTH,
    parameter int PipeLatency  = DEF_PIPE_LATENCY,
    parameter int ShortLatency = DEF_SHORT_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_issue_scheduler_if.slave bus
);
    localparam int BankW = $clog2(TotalNumBank);

    // slot[i] holds the op whose result is due i+1 cycles from now
    resv_entry_t               slot [1:PipeLatency];
    logic [PipeLatency:1]      slot_occ;
    resv_entry_t               new_entry;
    logic [2:0][BankW-1:0]     rd_bank;
    logic [2:0][AddrWidth-1:0] rd_addr;
    logic [2:0]                rd_busy, src_used, src_hit;
    logic [TotalNumBank-1:0]   row_busy, set_mask, clr_mask;
    logic                      raw, waw, coll, accept;

    assign new_entry = '{write_en: bus.dec_writeEn, write_addr: bus.dec_writeAddr};
    assign rd_bank   = {bus.dec_rs3_bank, bus.dec_rs2_bank, bus.dec_rs1_bank};
    assign rd_addr   = {bus.dec_rs3_addr, bus.dec_rs2_addr, bus.dec_rs1_addr};
    assign src_used  = {bus.dec_rs_used[2], bus.dec_rs_used[1] & ~bus.dec_ALUSrc, bus.dec_rs_used[0]};

`ifdef FPU_SCHED_EARLY_RELEASE_EN
    logic [TotalNumBank-1:0] wb_free_mask;

    always_comb begin
        wb_free_mask = bus.wb_valid ? bus.wb_writeEn : '0;
        src_hit      = '0;
        for (int k = 0; k < 3; k++) begin
            src_hit[k] = rd_busy[k] & ~(wb_free_mask[rd_bank[k]] & (bus.wb_writeAddr == rd_addr[k]));
        end
        waw = |(bus.dec_writeEn & row_busy
                & ~((bus.wb_writeAddr == bus.dec_writeAddr) ? wb_free_mask : '0));
    end
`else
    assign src_hit = rd_busy;
    assign waw     = |(bus.dec_writeEn & row_busy);
`endif

    assign raw = |(src_used & src_hit);

    // Long ops land in the top slot, which nothing can shift into, so only short ops collide.
    always_comb begin
        coll = 1'b0;
        if (!bus.dec_pipe && (bus.dec_writeEn != '0)) begin
            coll = slot_occ[ShortLatency+1];
        end
    end

    always_comb begin
        slot_occ = '0;
        for (int i = 1; i <= PipeLatency; i++) begin
            slot_occ[i] = |slot[i].write_en;
        end
    end

    assign bus.dec_ready = ~bus.dec_fp_en | ~(raw | waw | coll);
    assign accept        = bus.dec_valid & bus.dec_ready & bus.dec_fp_en;
    assign set_mask      = accept ? bus.dec_writeEn : '0;
    assign clr_mask      = bus.wb_valid ? bus.wb_writeEn : '0;
    assign bus.busy      = bus.iss_valid | (|slot_occ) | bus.wb_valid;

    fpu_scoreboard #(
        .NumBank   (TotalNumBank),
        .AddrWidth (AddrWidth)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rd_bank  (rd_bank),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .row_addr (bus.dec_writeAddr),
        .row_busy (row_busy),
        .set_mask (set_mask),
        .set_addr (bus.dec_writeAddr),
        .clr_mask (clr_mask),
        .clr_addr (bus.wb_writeAddr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= PipeLatency; i++) begin
                slot[i] <= '0;
            end
            bus.iss_valid     <= 1'b0;
            bus.iss_fp_opcode <= '0;
            bus.iss_fp_rm     <= '0;
            bus.iss_ALUSrc    <= 1'b0;
            bus.wb_valid      <= 1'b0;
            bus.wb_writeEn    <= '0;
            bus.wb_writeAddr  <= '0;
        end else begin
            for (int i = 1; i < PipeLatency; i++) begin
                slot[i] <= slot[i+1];
            end
            slot[PipeLatency] <= '0;
            if (accept && (bus.dec_writeEn != '0)) begin
                if (bus.dec_pipe) slot[PipeLatency]  <= new_entry;
                else              slot[ShortLatency] <= new_entry;
            end
            bus.iss_valid <= accept;
            if (accept) begin
                bus.iss_fp_opcode <= bus.dec_fp_opcode;
                bus.iss_fp_rm     <= bus.dec_fp_rm;
                bus.iss_ALUSrc    <= bus.dec_ALUSrc;
            end
            bus.wb_valid     <= slot_occ[1];
            bus.wb_writeEn   <= slot[1].write_en;
            bus.wb_writeAddr <= slot[1].write_addr;
        end
    end

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Bench for fpu_issue_scheduler: directed scenarios plus random traffic, checked
// against a cycle-indexed model of register free times and writeback reservations.
module tb_fpu_issue_scheduler;
    import fpu_pkg::*;

    localparam int NB   = 8;
    localparam int AW   = 5;
    localparam int PL   = DEF_PIPE_LATENCY;
    localparam int SL   = DEF_SHORT_LATENCY;
    localparam int NREG = 32;
    localparam int RING = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_issue_scheduler_if #(.TotalNumBank(NB), .AddrWidth(AW)) bus ();

    fpu_issue_scheduler #(
        .TotalNumBank (NB),
        .AddrWidth    (AW),
        .PipeLatency  (PL),
        .ShortLatency (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: cycle from which each register is free, and writeback reservations by cycle.
    int          free_at [NB][NREG];
    int          resv_tag [RING];
    logic [NB-1:0] resv_we [RING];
    logic [AW-1:0] resv_addr [RING];
    int          last_resv;
    logic        iss_exp;
    logic [16:0] iss_op_exp;
    logic [2:0]  iss_rm_exp;
    logic        iss_alu_exp;
    logic        accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < NREG; a++)
                free_at[b][a] = 0;
        for (int r = 0; r < RING; r++) begin
            resv_tag[r]  = -1;
            resv_we[r]   = '0;
            resv_addr[r] = '0;
        end
        last_resv = -1;
        iss_exp   = 1'b0;
    endfunction

    function automatic logic reg_busy(input int b, input int a);
        return free_at[b][a] > cyc;
    endfunction

    function automatic int lat(input logic p);
        return p ? PL : SL;
    endfunction

    function automatic logic slot_taken(input int w);
        return resv_tag[w % RING] == w;
    endfunction

    function automatic logic model_ready();
        int bk [3];
        int ad [3];
        if (!bus.dec_fp_en) return 1'b1;
        bk[0] = int'(bus.dec_rs1_bank); ad[0] = int'(bus.dec_rs1_addr);
        bk[1] = int'(bus.dec_rs2_bank); ad[1] = int'(bus.dec_rs2_addr);
        bk[2] = int'(bus.dec_rs3_bank); ad[2] = int'(bus.dec_rs3_addr);
        for (int k = 0; k < 3; k++)
            if (bus.dec_rs_used[k] && !(k == 1 && bus.dec_ALUSrc) && reg_busy(bk[k], ad[k]))
                return 1'b0;
        for (int b = 0; b < NB; b++)
            if (bus.dec_writeEn[b] && reg_busy(b, int'(bus.dec_writeAddr)))
                return 1'b0;
        if (bus.dec_writeEn != '0 && slot_taken(cyc + 1 + lat(bus.dec_pipe)))
            return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        logic rdy, wb_exp;
        int w;
        @(negedge clk);
        rdy    = model_ready();
        wb_exp = slot_taken(cyc);
        check("dec_ready", bus.dec_ready, rdy);
        check("iss_valid", bus.iss_valid, iss_exp);
        if (iss_exp) begin
            check("iss_fp_opcode", bus.iss_fp_opcode, iss_op_exp);
            check("iss_fp_rm", bus.iss_fp_rm, iss_rm_exp);
            check("iss_ALUSrc", bus.iss_ALUSrc, iss_alu_exp);
        end
        check("wb_valid", bus.wb_valid, wb_exp);
        if (wb_exp) begin
            check("wb_writeEn", bus.wb_writeEn, resv_we[cyc % RING]);
            check("wb_writeAddr", bus.wb_writeAddr, resv_addr[cyc % RING]);
        end
        check("busy", bus.busy, iss_exp || (last_resv >= cyc));
        accepted = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            accepted = bus.dec_valid && rdy;
            iss_exp  = accepted && bus.dec_fp_en;
            if (iss_exp) begin
                iss_op_exp  = bus.dec_fp_opcode;
                iss_rm_exp  = bus.dec_fp_rm;
                iss_alu_exp = bus.dec_ALUSrc;
                if (bus.dec_writeEn != '0) begin
                    w = cyc + 1 + lat(bus.dec_pipe);
                    resv_tag[w % RING]  = w;
                    resv_we[w % RING]   = bus.dec_writeEn;
                    resv_addr[w % RING] = bus.dec_writeAddr;
                    if (w > last_resv) last_resv = w;
                    for (int b = 0; b < NB; b++) begin
                        if (bus.dec_writeEn[b]) begin
`ifdef FPU_SCHED_EARLY_RELEASE_EN
                            free_at[b][int'(bus.dec_writeAddr)] = w;
`else
                            free_at[b][int'(bus.dec_writeAddr)] = w + 1;
`endif
                        end
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_op(input logic fp_en, input int opbit, input logic pipe,
                          input logic [NB-1:0] we, input int waddr,
                          input int rs1b, input int rs1a, input logic [2:0] used);
        bus.dec_fp_en     = fp_en;
        bus.dec_fp_opcode = 17'(1) << opbit;
        bus.dec_fp_rm     = 3'(opbit);
        bus.dec_pipe      = pipe;
        bus.dec_ALUSrc    = 1'b0;
        bus.dec_writeEn   = we;
        bus.dec_writeAddr = AW'(waddr);
        bus.dec_rs1_bank  = 3'(rs1b);
        bus.dec_rs1_addr  = AW'(rs1a);
        bus.dec_rs2_bank  = '0;
        bus.dec_rs2_addr  = '0;
        bus.dec_rs3_bank  = '0;
        bus.dec_rs3_addr  = '0;
        bus.dec_rs_used   = used;
    endtask

    task automatic present(input string tag);
        int n = 0;
        bus.dec_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!accepted && n < 20);
        if (!accepted) begin
            errors++;
            $display("FAIL %s_timeout cycle %0d got not accepted expected accepted", tag, cyc);
        end
        bus.dec_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.dec_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drive_random();
        int r;
        bus.dec_valid     = ($urandom_range(9) < 8);
        bus.dec_fp_en     = ($urandom_range(9) != 0);
        bus.dec_fp_opcode = 17'(1) << $urandom_range(16);
        bus.dec_fp_rm     = 3'($urandom_range(7));
        bus.dec_pipe      = 1'($urandom_range(1));
        bus.dec_ALUSrc    = 1'($urandom_range(1));
        r = $urandom_range(9);
        if (r == 0)      bus.dec_writeEn = '0;
        else if (r == 1) bus.dec_writeEn = (NB'(1) << $urandom_range(7)) | (NB'(1) << $urandom_range(7));
        else             bus.dec_writeEn = NB'(1) << $urandom_range(7);
        bus.dec_writeAddr = AW'($urandom_range(3));
        bus.dec_rs1_bank  = 3'($urandom_range(7));
        bus.dec_rs2_bank  = 3'($urandom_range(7));
        bus.dec_rs3_bank  = 3'($urandom_range(7));
        bus.dec_rs1_addr  = AW'($urandom_range(3));
        bus.dec_rs2_addr  = AW'($urandom_range(3));
        bus.dec_rs3_addr  = AW'($urandom_range(3));
        bus.dec_rs_used   = 3'($urandom_range(7));
    endtask

    initial begin
        model_reset();
        set_op(1'b1, OP_ADD, 1'b1, 8'b0000_0100, 5, 0, 0, 3'b000);
        bus.dec_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        step();
        rst = 1'b0;
        bus.dec_valid = 1'b0;
        idle(2);

        // single long ADD to b2r5
        set_op(1'b1, OP_ADD, 1'b1, 8'b0000_0100, 5, 0, 0, 3'b000);
        present("add");
        idle(6);

        // RAW: MUL reads b2r5 right behind its producer
        set_op(1'b1, OP_ADD, 1'b1, 8'b0000_0100, 5, 0, 0, 3'b000);
        present("raw_add");
        set_op(1'b1, OP_MUL, 1'b1, 8'b0000_1000, 6, 2, 5, 3'b001);
        present("raw_mul");
        idle(7);

        // writeback-port collision between long and short op
        set_op(1'b1, OP_ADD, 1'b1, 8'b0000_0001, 1, 0, 0, 3'b000);
        present("coll_add");
        idle(2);
        set_op(1'b1, OP_SGNJ, 1'b0, 8'b0000_0010, 2, 0, 0, 3'b000);
        present("coll_sgnj");
        idle(6);

        // back-to-back independent ADDs
        for (int i = 0; i < 4; i++) begin
            set_op(1'b1, OP_ADD, 1'b1, NB'(1) << i, 7, 0, 0, 3'b000);
            present("stream");
        end
        idle(6);

        // NOP ignores a pending hazard, then a reset drops an in-flight op
        set_op(1'b1, OP_ADD, 1'b1, 8'b0001_0000, 3, 0, 0, 3'b000);
        present("nop_add");
        set_op(1'b0, OP_ADD, 1'b1, 8'b0001_0000, 3, 4, 3, 3'b001);
        present("nop");
        idle(6);
        set_op(1'b1, OP_ADD, 1'b1, 8'b0010_0000, 6, 0, 0, 3'b000);
        present("rst_add");
        idle(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(8);

        for (int n = 0; n < 3000; n++) begin
            drive_random();
            rst = ($urandom_range(499) == 0);
            step();
            rst = 1'b0;
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_scheduler.md
# fpu_issue_scheduler

Issue scheduler between the decode stage's control unit and the floating-point unit. Accepts one decoded FP operation per cycle over a valid/ready handshake. Stalls on register hazards (RAW/WAW) via a per-bank scoreboard and on writeback-port collisions via a reservation shift register. Forwards the operation to the FPU and emits the matching register-file write strobe when the result is due.

## Interface
- TotalNumBank, 8, register banks; writeEn is one bit per bank
- AddrWidth, 5, register address width per bank
- PipeLatency, 4, issue-to-writeback cycles for pipe=1 ops (≥2)
- ShortLatency, 1, issue-to-writeback cycles for pipe=0 ops (< PipeLatency)
- BankW (localparam), $clog2(TotalNumBank)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decoded op present
- dec_ready  out  1  scheduler accepts op this cycle
- dec_fp_opcode  in  17  one-hot FPU opcode
- dec_fp_en  in  1  0 = NOP
- dec_fp_rm  in  3  rounding/sub-mode
- dec_writeEn  in  TotalNumBank  destination bank mask
- dec_writeAddr  in  AddrWidth  destination register
- dec_pipe  in  1  1 = long (pipelined) op
- dec_ALUSrc  in  1  1 = rs2 replaced by immediate
- dec_rs{1,2,3}_bank  in  BankW  source banks
- dec_rs{1,2,3}_addr  in  AddrWidth  source registers
- dec_rs_used  in  3  per-source valid; bit1 ignored when dec_ALUSrc=1
- iss_valid, iss_fp_opcode[17], iss_fp_rm[3], iss_ALUSrc  out  registered op to FPU
- wb_valid  out  1  result due this cycle
- wb_writeEn  out  TotalNumBank; wb_writeAddr  out  AddrWidth  write strobe for result
- busy  out  1  any op issued and not yet written back

## Operation
- Accept = dec_valid & dec_ready.
- NOP (dec_fp_en=0): dec_ready=1 regardless of hazards. Consumed; no issue, no reservation.
- Latency L = PipeLatency if dec_pipe else ShortLatency.
- dec_ready=0 when any of:
  - RAW: a used source (bank, addr) is busy in the scoreboard.
  - WAW: any bank set in dec_writeEn is busy at dec_writeAddr.
  - Collision: the writeback slot L cycles ahead is already reserved.
- On accept with fp_en=1:
  - iss_* registered.
  - Reservation slot L loaded with {writeEn, writeAddr}.
  - Scoreboard busy bits set for each bank in writeEn.
- dec_writeEn==0 with fp_en=1: issued normally; no slot, no scoreboard update, never stalls on collision.
- Reservation vector shifts one slot per cycle. Slot 1 drives wb_* on the next edge.
- Scoreboard bits clear on the clock edge that ends the wb_valid cycle.
- Set and clear of the same bit cannot coincide; WAW blocks it.
- busy = iss_valid | any reservation slot occupied | wb_valid.

## Timing
- Op accepted in cycle T:
  - iss_valid high in cycle T+1 only.
  - wb_valid high in cycle T+1+L only.
- Throughput: one op per cycle when there are no hazards.
- dec_ready is combinational from current state; it does not depend on dec_valid.
- Dependent op: earliest accept is cycle T+2+L (no early release).
- Reset: all outputs 0, scoreboard and reservations cleared.
  - dec_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: in-flight ops are dropped; no wb_valid is produced for them.

## Configuration
- FPU_SCHED_EARLY_RELEASE_EN defined:
  - Registers being written back in the current cycle are treated as free for RAW/WAW checks.
  - A dependent op may be accepted in cycle T+1+L, the same cycle as wb_valid.
  - A re-set of a bit being cleared wins: the bit stays busy.
- Undefined: a register is free only from the cycle after its wb_valid.

## Structure
- Shared package fpu_pkg holds:
  - fp_opcode bit indices (MADD 16, MSUB 15, NMADD 14, NMSUB 13, ADD 12, SUB 11, MUL 10, SGNJ 9, CMP 8, MINMAX 7, CLASS 6, I2F 3, F2I 2)
  - default PipeLatency
  - reservation-entry struct {writeEn, writeAddr}
- Sub-module fpu_scoreboard: TotalNumBank × 2^AddrWidth busy array, 3 read ports, one set port, one clear port.

## Test plan
- Reset: rst high 2 cycles while dec_valid=1 → iss_valid=wb_valid=busy=0; dec_ready=1 in the cycle after release.
- Single ADD (pipe=1, writeEn=8'b0000_0100, addr 5) accepted cycle 10 → iss_valid cycle 11, wb_valid cycle 15 with wb_writeEn=8'b0000_0100, wb_writeAddr=5.
- RAW: ADD→b2r5 accepted cycle 10, then MUL reading b2r5 → dec_ready=0 cycles 11–15, accepted cycle 16 (cycle 15 with FPU_SCHED_EARLY_RELEASE_EN).
- Collision: ADD (pipe=1) accepted cycle 10, independent SGNJ (pipe=0) presented cycle 13 → stalled, accepted 14; wb_valid cycles 15 and 16.
- Streaming: 4 independent ADDs on consecutive cycles 10–13 → no stall, wb_valid cycles 15–18 with matching addresses.
- NOP while a hazard is pending → accepted immediately, no iss_valid. Then rst pulse at cycle 12 with an ADD in flight → no wb_valid afterwards, busy=0.
